// File: rtl/one_bit_adder_dec_if.sv
// ----------------------------------------------------------------------------
// one_bit_adder_dec_if
// Bundles the data/qualifier signals of one one_bit_adder_dec cell so a
// driver and a consumer can be handed a single handle.
//   master : drives a, b, cin, in_valid; observes sum, cout, out_valid, minterm
//   slave  : the adder side of the same signals
// clk and rst_n stay outside the bundle.
// ----------------------------------------------------------------------------
interface one_bit_adder_dec_if;
   logic       a;
   logic       b;
   logic       cin;
   logic       in_valid;
   logic       sum;
   logic       cout;
   logic       out_valid;
   logic [7:0] minterm;

   modport master (
      output a, b, cin, in_valid,
      input  sum, cout, out_valid, minterm
   );

   modport slave (
      input  a, b, cin, in_valid,
      output sum, cout, out_valid, minterm
   );
endinterface

// File: rtl/one_bit_adder_dec.sv
// ----------------------------------------------------------------------------
// one_bit_adder_dec
// 1-bit full adder built from a 3-to-8 one-hot decoder on {a, b, cin}
// (a = MSB) with OR reduction of the minterms. Leaf cell of ripple-carry
// decoder adders; the port order is fixed so chains can connect positionally.
//   sum       out : a ^ b ^ cin
//   cout      out : majority(a, b, cin)
//   a, b      in  : addend bits
//   cin       in  : carry-in
//   clk       in  : clock, only used when REGISTERED = 1
//   rst_n     in  : async active-low reset, only affects REGISTERED = 1
//   in_valid  in  : input qualifier
//   out_valid out : in_valid, delayed one cycle when REGISTERED = 1
//   minterm   out : one-hot decoder vector (all-zero only while in reset)
// REGISTERED = 0 : purely combinational, no state.
// REGISTERED = 1 : all outputs captured every rising clk, 1-cycle latency.
// ----------------------------------------------------------------------------
module one_bit_adder_dec #(
   parameter bit REGISTERED = 1'b0
) (
   output logic       sum,
   output logic       cout,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       out_valid,
   output logic [7:0] minterm
);

   logic [2:0] w_idx;
   logic [7:0] w_minterm;
   logic       w_sum;
   logic       w_cout;

   assign w_idx = {a, b, cin};

   // Decoder is always enabled: exactly one bit set.
   always_comb begin
      w_minterm        = 8'h00;
      w_minterm[w_idx] = 1'b1;
   end

   // Odd-parity minterms give sum, two-or-more-ones minterms give carry.
   assign w_sum  = w_minterm[1] | w_minterm[2] | w_minterm[4] | w_minterm[7];
   assign w_cout = w_minterm[3] | w_minterm[5] | w_minterm[6] | w_minterm[7];

   if (REGISTERED) begin : g_reg
      logic       r_sum;
      logic       r_cout;
      logic       r_valid;
      logic [7:0] r_minterm;

      // Capture every cycle; in_valid only travels alongside as a qualifier.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sum     <= 1'b0;
            r_cout    <= 1'b0;
            r_valid   <= 1'b0;
            r_minterm <= 8'h00;
         end else begin
            r_sum     <= w_sum;
            r_cout    <= w_cout;
            r_valid   <= in_valid;
            r_minterm <= w_minterm;
         end
      end

      assign sum       = r_sum;
      assign cout      = r_cout;
      assign out_valid = r_valid;
      assign minterm   = r_minterm;
   end else begin : g_comb
      // clk/rst_n are part of the shared port list but unused here.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign sum       = w_sum;
      assign cout      = w_cout;
      assign out_valid = in_valid;
      assign minterm   = w_minterm;
   end

endmodule

// File: tb/tb_one_bit_adder_dec.sv
// ----------------------------------------------------------------------------
// tb_one_bit_adder_dec
// Self-checking bench: a combinational cell, a registered cell and an 8-bit
// ripple chain of combinational cells, compared against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_one_bit_adder_dec;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   one_bit_adder_dec_if if_c ();
   one_bit_adder_dec_if if_r ();

   one_bit_adder_dec #(.REGISTERED(1'b0)) u_comb (
      .sum       (if_c.sum),
      .cout      (if_c.cout),
      .a         (if_c.a),
      .b         (if_c.b),
      .cin       (if_c.cin),
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (if_c.in_valid),
      .out_valid (if_c.out_valid),
      .minterm   (if_c.minterm)
   );

   one_bit_adder_dec #(.REGISTERED(1'b1)) u_reg (
      .sum       (if_r.sum),
      .cout      (if_r.cout),
      .a         (if_r.a),
      .b         (if_r.b),
      .cin       (if_r.cin),
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (if_r.in_valid),
      .out_valid (if_r.out_valid),
      .minterm   (if_r.minterm)
   );

   // 8-bit ripple chain
   logic [7:0] rip_a;
   logic [7:0] rip_b;
   logic       rip_cin;
   logic [8:0] rip_c;
   logic [7:0] rip_sum;
   logic [7:0] rip_ov;
   logic [7:0] rip_mt [8];

   assign rip_c[0] = rip_cin;

   for (genvar j = 0; j < 8; j++) begin : g_rip
      one_bit_adder_dec #(.REGISTERED(1'b0)) u_cell (
         .sum       (rip_sum[j]),
         .cout      (rip_c[j+1]),
         .a         (rip_a[j]),
         .b         (rip_b[j]),
         .cin       (rip_c[j]),
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (1'b1),
         .out_valid (rip_ov[j]),
         .minterm   (rip_mt[j])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: full add as plain arithmetic, result {cout, sum}.
   function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
      int s;
      s = int'(x) + int'(y) + int'(z);
      return s[1:0];
   endfunction

   function automatic logic [7:0] ref_mt(input logic x, input logic y, input logic z);
      int k;
      k = 4 * int'(x) + 2 * int'(y) + int'(z);
      return 8'(1 << k);
   endfunction

   task automatic check_ripple(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic c);
      logic [8:0] exp;
      rip_a   = x;
      rip_b   = y;
      rip_cin = c;
      #1;
      exp = 9'(x) + 9'(y) + 9'(c);
      check({tag, ".sum"}, 32'(rip_sum), 32'(exp[7:0]));
      check({tag, ".cout"}, 32'(rip_c[8]), 32'(exp[8]));
   endtask

   // Expected registered outputs, computed from what was driven before the edge.
   logic [1:0] e_cs;
   logic [7:0] e_mt;
   logic       e_v;

   task automatic drive_r(input logic x, input logic y, input logic z, input logic v);
      if_r.a        = x;
      if_r.b        = y;
      if_r.cin      = z;
      if_r.in_valid = v;
      e_cs          = ref_add(x, y, z);
      e_mt          = ref_mt(x, y, z);
      e_v           = v;
   endtask

   task automatic check_r(input string tag);
      check({tag, ".sum"}, 32'(if_r.sum), 32'(e_cs[0]));
      check({tag, ".cout"}, 32'(if_r.cout), 32'(e_cs[1]));
      check({tag, ".minterm"}, 32'(if_r.minterm), 32'(e_mt));
      check({tag, ".out_valid"}, 32'(if_r.out_valid), 32'(e_v));
   endtask

   task automatic check_r_zero(input string tag);
      check({tag, ".sum"}, 32'(if_r.sum), 32'd0);
      check({tag, ".cout"}, 32'(if_r.cout), 32'd0);
      check({tag, ".minterm"}, 32'(if_r.minterm), 32'd0);
      check({tag, ".out_valid"}, 32'(if_r.out_valid), 32'd0);
   endtask

   initial begin
      logic [1:0] cs;
      logic [2:0] v3;
      logic       iv;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      if_c.a = 1'b0; if_c.b = 1'b0; if_c.cin = 1'b0; if_c.in_valid = 1'b0;
      drive_r(1'b1, 1'b1, 1'b1, 1'b1);
      rip_a = 8'h00; rip_b = 8'h00; rip_cin = 1'b0;

      // Reset state of the registered cell, clock running, inputs non-zero.
      #3;
      check_r_zero("reset");
      @(posedge clk);
      #1;
      check_r_zero("reset_edge");

      // Combinational cell: exhaustive, unaffected by reset being held.
      for (int i = 0; i < 8; i++) begin
         v3 = 3'(i);
         iv = v3[0] ^ v3[2];
         if_c.a = v3[2]; if_c.b = v3[1]; if_c.cin = v3[0]; if_c.in_valid = iv;
         #1;
         cs = ref_add(v3[2], v3[1], v3[0]);
         check($sformatf("comb%0d.sum", i), 32'(if_c.sum), 32'(cs[0]));
         check($sformatf("comb%0d.cout", i), 32'(if_c.cout), 32'(cs[1]));
         check($sformatf("comb%0d.minterm", i), 32'(if_c.minterm),
               32'(ref_mt(v3[2], v3[1], v3[0])));
         check($sformatf("comb%0d.out_valid", i), 32'(if_c.out_valid), 32'(iv));
      end

      // Ripple chain: directed then random.
      check_ripple("rip15p1", 8'd15, 8'd1, 1'b0);
      check_ripple("rip1p7", 8'd1, 8'd7, 1'b0);
      check_ripple("rip255p1", 8'd255, 8'd1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         check_ripple($sformatf("rip_rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
         check("rip_ov", 32'(rip_ov), 32'hff);
         check("rip_mt_onehot", 32'($onehot(rip_mt[i % 8])), 32'd1);
      end

      // Release reset between edges; first capture on the following edge.
      @(negedge clk);
      rst_n = 1'b1;
      drive_r(1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      check_r_zero("post_release_pre_edge");
      @(posedge clk);
      #1;
      check_r("lat_edge_n");
      // Change inputs mid-cycle: outputs must hold until the next edge.
      if_r.a = 1'b0; if_r.b = 1'b0; if_r.cin = 1'b0; if_r.in_valid = 1'b0;
      @(negedge clk);
      check_r("lat_hold");
      drive_r(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_r("lat_edge_n1");

      // Valid pipeline 1,0,1 with changing data.
      @(negedge clk); drive_r(1'b0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1; check_r("vp1");
      @(negedge clk); drive_r(1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1; check_r("vp0");
      @(negedge clk); drive_r(1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1; check_r("vp1b");

      // Random registered stream.
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive_r(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         @(posedge clk);
         #1;
         check_r($sformatf("reg_rnd%0d", i));
      end

      // Async reset mid-stream, without a clock edge.
      @(negedge clk);
      drive_r(1'b1, 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_r("pre_async");
      #2;
      rst_n = 1'b0;
      #1;
      check_r_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_r_zero("async_rel_hold");
      @(posedge clk);
      #1;
      check_r("async_restore");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
